// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - boot loader: host byte stream -> 16-bit words -> Hack instruction ROM
// Holds the CPU in reset until a complete, length-checked image has been written.
module hack_rom_loader #(
   parameter int ADDR_WIDTH     = 15,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  rom_we,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic [DATA_WIDTH-1:0] rom_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_LEN_LO = 3'd2;
   localparam logic [2:0] S_DAT_HI = 3'd3;
   localparam logic [2:0] S_DAT_LO = 3'd4;
   localparam logic [2:0] S_WRITE  = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;

   // Length arithmetic is one bit wider than the address so N == 2^ADDR_WIDTH is representable.
   localparam int          LW       = (ADDR_WIDTH >= 16) ? ADDR_WIDTH + 1 : 17;
   localparam logic [LW-1:0] MAX_LEN = LW'(1) << ADDR_WIDTH;
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [2:0]            state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [7:0]            hi_q, hi_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [31:0]           tmo_q, tmo_d;
   logic                  rx_ready_q, rx_ready_d;
   logic                  rom_we_q, rom_we_d;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
   logic [DATA_WIDTH-1:0] rom_wdata_q, rom_wdata_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic        accept;
   logic        accepting;
   logic [15:0] len_in;
   logic        last_word;

   assign accept    = rx_valid & rx_ready_q;
   assign accepting = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DAT_HI) || (state_q == S_DAT_LO);
   assign len_in    = {len_q[15:8], rx_data};
   assign last_word = (LW'(idx_q) == (LW'(len_q) - LW'(1)));

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      hi_d        = hi_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      rom_addr_d  = rom_addr_q;
      rom_wdata_d = rom_wdata_q;

      // Idle-gap watchdog; an accept always wins over expiry in the same cycle.
      if (accepting) begin
         if (accept) begin
            tmo_d = 32'd0;
         end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
            state_d = S_ERROR;
         end else begin
            tmo_d = tmo_q + 32'd1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_HI;
               idx_d   = '0;
               tmo_d   = 32'd0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = rx_data;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = rx_data;
               if ((len_in == 16'd0) || (LW'(len_in) > MAX_LEN)) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_DAT_HI;
               end
            end
         end
         S_DAT_HI: begin
            if (accept) begin
               hi_d    = rx_data;
               state_d = S_DAT_LO;
            end
         end
         S_DAT_LO: begin
            if (accept) begin
               rom_addr_d  = idx_q;
               rom_wdata_d = DATA_WIDTH'({hi_q, rx_data});
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            if (last_word) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + ADDR_WIDTH'(1);
               state_d = S_DAT_HI;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      rx_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                    (state_d == S_DAT_HI) || (state_d == S_DAT_LO);
      rom_we_d    = (state_d == S_WRITE);
      busy_d      = rx_ready_d || (state_d == S_WRITE);
      done_d      = (state_d == S_DONE);
      err_d       = (state_d == S_ERROR);
      cpu_reset_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= 16'd0;
         hi_q        <= 8'd0;
         idx_q       <= '0;
         tmo_q       <= 32'd0;
         rx_ready_q  <= 1'b0;
         rom_we_q    <= 1'b0;
         rom_addr_q  <= '0;
         rom_wdata_q <= '0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         hi_q        <= hi_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         rx_ready_q  <= rx_ready_d;
         rom_we_q    <= rom_we_d;
         rom_addr_q  <= rom_addr_d;
         rom_wdata_q <= rom_wdata_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign rom_we    = rom_we_q;
   assign rom_addr  = rom_addr_q;
   assign rom_wdata = rom_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
